// File: rtl/ofdm_symbol_scheduler_if.sv
// Byte stream bundle between the source generator, the symbol scheduler and the QAM mapper.
// The scheduler takes the slave view; the source/sink side takes the master view.
interface ofdm_symbol_scheduler_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_sof;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last, m_sof
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_sof
    );
endinterface

// File: rtl/ofdm_symbol_scheduler.sv
// OFDM symbol scheduler: gates the byte source, frames bytes into fixed-length symbols
// with an idle gap after each one for CP insertion, and registers them toward the mapper.
module ofdm_symbol_scheduler #(
    parameter int N_SUB       = 16,
    parameter int BITS_PER_SC = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [7:0]             num_symbols,
    input  logic                   abort,
    ofdm_symbol_scheduler_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             sym_index
);
    localparam int BYTES_PER_SYM = N_SUB * BITS_PER_SC / 8;
    localparam int BC_W          = $clog2(BYTES_PER_SYM + 1);
    localparam int GC_W          = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_GAP, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [BC_W-1:0] r_byte_cnt, w_byte_nxt;
    logic [GC_W-1:0] r_gap_cnt, w_gap_nxt;
    logic [7:0]      r_sym_cnt, w_sym_nxt;
    logic [7:0]      r_num_sym, w_num_nxt;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_last;
    logic            r_sof;

    logic w_abort;
    logic w_out_free;
    logic w_s_ready;
    logic w_xfer;
    logic w_last_byte;
    logic w_last_sym;
    logic w_gap_end;

    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_out_free  = !r_valid || bus.m_ready;
    // abort withholds s_ready so the source never advances on a byte that would be discarded
    assign w_s_ready   = (r_state == S_PAYLOAD) && (r_byte_cnt < BC_W'(BYTES_PER_SYM))
                         && w_out_free && !w_abort;
    assign w_xfer      = w_s_ready && bus.s_valid;
    assign w_last_byte = (r_byte_cnt == BC_W'(BYTES_PER_SYM - 1));
    assign w_last_sym  = (r_sym_cnt == r_num_sym - 8'd1);
    // the final gap cycle is the one whose decrement reaches zero
    assign w_gap_end   = (r_gap_cnt <= GC_W'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
            r_sym_cnt  <= '0;
            r_num_sym  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_sym_cnt  <= w_sym_nxt;
            r_num_sym  <= w_num_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_sym_nxt   = r_sym_cnt;
        w_num_nxt   = r_num_sym;
        case (r_state)
            S_IDLE: begin
                if (start && (num_symbols != 8'd0)) begin
                    w_num_nxt   = num_symbols;
                    w_byte_nxt  = '0;
                    w_sym_nxt   = '0;
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_xfer) begin
                    w_byte_nxt = r_byte_cnt + BC_W'(1);
                    if (w_last_byte) begin
                        // without a gap, move straight into the next symbol to keep 1 byte/cycle
                        if ((GAP_CYCLES == 0) && !w_last_sym) begin
                            w_sym_nxt  = r_sym_cnt + 8'd1;
                            w_byte_nxt = '0;
                        end else begin
                            w_gap_nxt   = GC_W'(GAP_CYCLES);
                            w_state_nxt = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_nxt = r_gap_cnt - GC_W'(1);
                end
                if (w_gap_end) begin
                    if (w_last_sym) begin
                        if (!r_valid) begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_sym_nxt   = r_sym_cnt + 8'd1;
                        w_byte_nxt  = '0;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_byte_nxt  = '0;
            w_gap_nxt   = '0;
            w_sym_nxt   = '0;
            w_num_nxt   = '0;
        end
    end

    // output register: loads on a source transfer, empties on a drain with no new load
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sof   <= 1'b0;
        end else if (w_abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sof   <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= bus.s_data;
            r_valid <= 1'b1;
            r_last  <= w_last_byte;
            r_sof   <= (r_byte_cnt == '0) && (r_sym_cnt == 8'd0);
        end else if (r_valid && bus.m_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sof   <= 1'b0;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_data  = r_data;
    assign bus.m_valid = r_valid;
    assign bus.m_last  = r_last;
    assign bus.m_sof   = r_sof;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign sym_index   = r_sym_cnt;
endmodule
